// File: rtl/serializer_with_stuffing.sv
// Parallel-to-serial front end, MSB first, alternating idle pattern between words.
// Define SERIALIZER_STUFF_EN to insert a complementary stuff bit after RUN_LEN identical bits.
module serializer_with_stuffing #(
  parameter int WIDTH   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             stuff
);

`ifdef SERIALIZER_STUFF_EN
  localparam logic STUFF_EN = 1'b1;
`else
  localparam logic STUFF_EN = 1'b0;
`endif

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(RUN_LEN);
  localparam logic [RW-1:0] RUN_ONE  = RW'(1);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_STUFF, SLOT_SHIFT, SLOT_LOAD} slot_e;

  logic [WIDTH-1:0] shreg, nxt_shreg;
  logic [CW-1:0]    bit_cnt, nxt_bit_cnt;
  logic [RW-1:0]    run_cnt, nxt_run_cnt;
  logic             last_bit, nxt_bit;
  logic             nxt_w_valid, nxt_stuff, stuff_q;
  logic             stuff_due;
  slot_e            slot;

  assign stuff_due = STUFF_EN && (run_cnt == RUN_MAX);
  assign din_ready = (bit_cnt == '0) && !stuff_due;
  assign stuff     = STUFF_EN & stuff_q;

  always_comb begin
    if (stuff_due)                   slot = SLOT_STUFF;
    else if (bit_cnt != '0)          slot = SLOT_SHIFT;
    else if (din_valid && din_ready) slot = SLOT_LOAD;
    else                             slot = SLOT_IDLE;
  end

  always_comb begin
    nxt_shreg   = shreg;
    nxt_bit_cnt = bit_cnt;
    nxt_bit     = ~last_bit;
    nxt_w_valid = 1'b0;
    nxt_stuff   = 1'b0;
    case (slot)
      SLOT_STUFF: nxt_stuff = 1'b1;
      SLOT_SHIFT: begin
        nxt_bit     = shreg[WIDTH-1];
        nxt_w_valid = 1'b1;
        nxt_shreg   = {shreg[WIDTH-2:0], 1'b0};
        nxt_bit_cnt = bit_cnt - CNT_ONE;
      end
      SLOT_LOAD: begin
        nxt_bit     = din[WIDTH-1];
        nxt_w_valid = 1'b1;
        nxt_shreg   = {din[WIDTH-2:0], 1'b0};
        nxt_bit_cnt = CNT_LAST;
      end
      default: ;
    endcase
    // Idle and stuff bits always flip the line, so only data bits can extend a run.
    if (nxt_bit == last_bit)
      nxt_run_cnt = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + RUN_ONE;
    else
      nxt_run_cnt = RUN_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      run_cnt  <= RUN_ONE;
      last_bit <= 1'b0;
      w        <= 1'b0;
      w_valid  <= 1'b0;
      stuff_q  <= 1'b0;
    end else begin
      shreg    <= nxt_shreg;
      bit_cnt  <= nxt_bit_cnt;
      run_cnt  <= nxt_run_cnt;
      last_bit <= nxt_bit;
      w        <= nxt_bit;
      w_valid  <= nxt_w_valid;
      stuff_q  <= nxt_stuff;
    end
  end

endmodule

// File: tb/tb_serializer_with_stuffing.sv
// Directed bench for serializer_with_stuffing (WIDTH=8, RUN_LEN=3); expectations follow SERIALIZER_STUFF_EN.
module tb_serializer_with_stuffing;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, w, w_valid, stuff;
  int         tests = 0;
  int         fails = 0;

  serializer_with_stuffing #(.WIDTH(8), .RUN_LEN(3)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .w(w), .w_valid(w_valid), .stuff(stuff)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       vld;
    logic       rdy;
    logic       w;
    logic       wv;
    logic       st;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Starts and ends on a falling edge: drive, check ready, clock, check registered outputs.
  task automatic cycle(input string tag, input logic [7:0] d, input logic v,
                       input logic er, input logic ew, input logic ewv, input logic est);
    din = d;
    din_valid = v;
    #1;
    chk({tag, " din_ready"}, din_ready, er);
    @(posedge clk);
    #1;
    chk({tag, " w"}, w, ew);
    chk({tag, " w_valid"}, w_valid, ewv);
    chk({tag, " stuff"}, stuff, est);
    @(negedge clk);
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset w", w, 1'b0);
    chk("reset w_valid", w_valid, 1'b0);
    chk("reset stuff", stuff, 1'b0);
    chk("reset din_ready", din_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] word;
    logic [10:0] ew, ewv, est;
    logic [7:0]  a5;

    a5 = 8'hA5;
    // idle after reset, then A5 with no stuffing needed, then one idle slot
    for (int i = 0; i < 4; i++)
      tbl[i] = '{din: 8'h00, vld: 1'b0, rdy: 1'b1, w: (i % 2 == 0), wv: 1'b0, st: 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[4+i] = '{din: (i == 0) ? a5 : 8'h00, vld: (i == 0), rdy: (i == 0),
                   w: a5[7-i], wv: 1'b1, st: 1'b0};
    tbl[12] = '{din: 8'h00, vld: 1'b0, rdy: 1'b1, w: 1'b0, wv: 1'b0, st: 1'b0};

    do_reset();
    for (int i = 0; i < 13; i++)
      cycle($sformatf("tbl[%0d]", i), tbl[i].din, tbl[i].vld, tbl[i].rdy,
            tbl[i].w, tbl[i].wv, tbl[i].st);

`ifdef SERIALIZER_STUFF_EN
    // FF straight after reset: a stuff bit after every third 1
    do_reset();
    ew  = 11'b11101110110;
    ewv = 11'b11101110110;
    est = 11'b00010001000;
    for (int k = 0; k < 11; k++)
      cycle($sformatf("ff k%0d", k), 8'hFF, (k == 0), (k == 0 || k == 10),
            ew[10-k], ewv[10-k], est[10-k]);

    // 07 ends on a 3-run: stuff at the word boundary holds off the waiting word
    do_reset();
    cycle("07 pre", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    ew  = 11'b00010011101;
    ewv = 11'b11101111100;
    est = 11'b00010000010;
    for (int k = 0; k < 11; k++)
      cycle($sformatf("07 k%0d", k), 8'h07, (k < 10), (k == 0 || k == 10),
            ew[10-k], ewv[10-k], est[10-k]);
`else
    // 00 then FF back-to-back: 16 data bits, ready once per 8 cycles
    do_reset();
    for (int k = 0; k < 17; k++)
      cycle($sformatf("b2b k%0d", k), (k == 0) ? 8'h00 : 8'hFF, (k < 16),
            (k == 0 || k == 8 || k == 16), (k >= 8 && k < 16), (k < 16), 1'b0);
`endif

    // reset mid-word: C3 cut after 3 bits, remainder never appears
    do_reset();
    cycle("c3 k0", 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle("c3 k1", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("c3 k2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midrst w", w, 1'b0);
    chk("midrst w_valid", w_valid, 1'b0);
    chk("midrst stuff", stuff, 1'b0);
    chk("midrst din_ready", din_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++)
      cycle($sformatf("after rst k%0d", k), 8'h00, 1'b0, 1'b1, (k % 2 == 0), 1'b0, 1'b0);

    // backpressure: din churns while busy, only ready-cycle values are sent
    do_reset();
    word = 16'hA55A;
    for (int k = 0; k < 17; k++)
      cycle($sformatf("bp k%0d", k),
            (k == 0) ? 8'hA5 : (k == 8) ? 8'h5A : 8'((k * 37) ^ 8'hC3),
            (k < 16), (k == 0 || k == 8 || k == 16),
            (k < 16) ? word[15-k] : 1'b1, (k < 16), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
